// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache-line port to 4-beat 64-bit burst memory adapter
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  line_address_i,
    input  logic [255:0] line_wdata_i,
    input  logic         line_read_i,
    input  logic         line_write_i,
    output logic         line_resp_o,
    output logic [255:0] line_rdata_o,
    output logic [31:0]  burst_address_o,
    output logic         burst_read_o,
    output logic         burst_write_o,
    output logic [63:0]  burst_wdata_o,
    input  logic [63:0]  burst_rdata_i,
    input  logic         burst_resp_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   beat;
    logic [31:0]  addr_q;
    logic [255:0] wdata_q;
    logic [255:0] rdata_q;
    logic         last_beat;

    assign last_beat = burst_resp_i && (beat == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write has priority over read when both requests arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (line_write_i) begin
                    state_nxt = WRITE;
                end else if (line_read_i) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request address and write line are captured once at accept; the
    // upstream side may change them freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat    <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 256'd0;
            rdata_q <= 256'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write_i || line_read_i) begin
                        addr_q <= line_address_i & 32'hFFFF_FFE0;
                        beat   <= 2'd0;
                    end
                    if (line_write_i) begin
                        wdata_q <= line_wdata_i;
                    end
                end
                READ: begin
                    if (burst_resp_i) begin
                        rdata_q[{beat, 6'd0} +: 64] <= burst_rdata_i;
                        beat                        <= beat + 2'd1;
                    end
                end
                WRITE: begin
                    if (burst_resp_i) begin
                        beat <= beat + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        line_resp_o     = (state == DONE);
        burst_read_o    = (state == READ);
        burst_write_o   = (state == WRITE);
        burst_address_o = addr_q;
        burst_wdata_o   = wdata_q[{beat, 6'd0} +: 64];
        line_rdata_o    = rdata_q;
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_address_i;
    logic [255:0] line_wdata_i;
    logic         line_read_i;
    logic         line_write_i;
    logic         line_resp_o;
    logic [255:0] line_rdata_o;
    logic [31:0]  burst_address_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i;
    logic         burst_resp_i;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WR_LINE = {64'hDEAD_3333_3333_BEEF, 64'hDEAD_2222_2222_BEEF,
                                        64'hDEAD_1111_1111_BEEF, 64'hDEAD_0000_0000_BEEF};
    localparam logic [255:0] WR_LINE2 = {64'hA5A5_0303_0303_5A5A, 64'hA5A5_0202_0202_5A5A,
                                         64'hA5A5_0101_0101_5A5A, 64'hA5A5_0000_0000_5A5A};
    localparam logic [255:0] RD_LINE2 = {64'hC3C3_C3C3_0000_0004, 64'hC3C3_C3C3_0000_0003,
                                         64'hC3C3_C3C3_0000_0002, 64'hC3C3_C3C3_0000_0001};
    localparam logic [255:0] RD_LINE3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h0F0F_F0F0_0F0F_F0F0, 64'h8000_0000_0000_0001};

    cacheline_adapter dut (
        .clk             (clk),
        .rst             (rst),
        .line_address_i  (line_address_i),
        .line_wdata_i    (line_wdata_i),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_resp_o     (line_resp_o),
        .line_rdata_o    (line_rdata_o),
        .burst_address_o (burst_address_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_wdata_o   (burst_wdata_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_resp_i    (burst_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp"}, line_resp_o, 0);
        chk({tag, "_rdata"}, line_rdata_o, 0);
        chk({tag, "_baddr"}, burst_address_o, 0);
        chk({tag, "_brw"}, {burst_read_o, burst_write_o}, 0);
        chk({tag, "_bwdata"}, burst_wdata_o, 0);
    endtask

    // Zero-wait read of one line; leaves the DUT in IDLE with the request dropped.
    task automatic run_read(input string tag, input logic [31:0] a, input logic [255:0] line);
        line_address_i = a;
        line_read_i    = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_bread"}, burst_read_o, 1);
            chk({tag, "_baddr"}, burst_address_o, a & 32'hFFFF_FFE0);
            chk({tag, "_early_resp"}, line_resp_o, 0);
            burst_resp_i  = 1'b1;
            burst_rdata_i = line[k*64 +: 64];
            tick();
        end
        burst_resp_i = 1'b0;
        chk({tag, "_resp"}, line_resp_o, 1);
        chk({tag, "_bread_done"}, burst_read_o, 0);
        chk({tag, "_rdata"}, line_rdata_o, line);
        line_read_i = 1'b0;
        tick();
        chk({tag, "_resp_pulse"}, line_resp_o, 0);
        chk({tag, "_idle"}, {burst_read_o, burst_write_o}, 0);
    endtask

    initial begin
        int wcnt;
        int rcnt;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            line_address_i = $urandom;
            line_wdata_i   = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
            line_read_i    = 1'($urandom);
            line_write_i   = 1'($urandom);
            burst_rdata_i  = {$urandom, $urandom};
            burst_resp_i   = 1'($urandom);
            tick();
            chk_all_zero("reset");
        end
        rst            = 1'b0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        burst_resp_i   = 1'b0;
        line_address_i = 32'd0;
        line_wdata_i   = 256'd0;
        burst_rdata_i  = 64'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_quiet", {burst_read_o, burst_write_o, line_resp_o}, 0);
        end

        run_read("rd0", 32'h0000_1234, RD_LINE);

        // Write with two wait cycles before each beat; inputs disturbed after accept.
        line_address_i = 32'h8000_0040;
        line_wdata_i   = WR_LINE;
        line_write_i   = 1'b1;
        tick();
        line_address_i = 32'hFFFF_FFFF;
        line_wdata_i   = ~WR_LINE;
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                chk("wr_wdata", burst_wdata_o, WR_LINE[k*64 +: 64]);
                chk("wr_baddr", burst_address_o, 32'h8000_0040);
                chk("wr_early_resp", line_resp_o, 0);
                if (burst_write_o) wcnt++;
                burst_resp_i = (w == 2);
                tick();
            end
        end
        burst_resp_i = 1'b0;
        chk("wr_resp", line_resp_o, 1);
        chk("wr_bwrite_done", burst_write_o, 0);
        chk("wr_cycles", wcnt, 12);
        line_write_i = 1'b0;
        tick();
        chk("wr_resp_pulse", line_resp_o, 0);

        // Simultaneous read and write: write only, read data untouched.
        line_address_i = 32'h0000_011F;
        line_wdata_i   = WR_LINE2;
        line_read_i    = 1'b1;
        line_write_i   = 1'b1;
        tick();
        rcnt = 0;
        for (int k = 0; k < 4; k++) begin
            chk("both_bwrite", burst_write_o, 1);
            chk("both_wdata", burst_wdata_o, WR_LINE2[k*64 +: 64]);
            if (burst_read_o) rcnt++;
            burst_resp_i = 1'b1;
            tick();
        end
        burst_resp_i = 1'b0;
        chk("both_resp", line_resp_o, 1);
        chk("both_baddr", burst_address_o, 32'h0000_0100);
        chk("both_no_read", rcnt, 0);
        chk("both_rdata_kept", line_rdata_o, RD_LINE);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        tick();

        // Back-to-back: write raised in the IDLE cycle right after the read response.
        line_address_i = 32'h0000_2000;
        line_read_i    = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = RD_LINE2[k*64 +: 64];
            tick();
        end
        burst_resp_i = 1'b0;
        chk("b2b_rd_resp", line_resp_o, 1);
        chk("b2b_rd_rdata", line_rdata_o, RD_LINE2);
        line_read_i = 1'b0;
        tick();
        line_address_i = 32'h0000_3000;
        line_wdata_i   = WR_LINE;
        line_write_i   = 1'b1;
        chk("b2b_idle", {burst_read_o, burst_write_o, line_resp_o}, 0);
        tick();
        chk("b2b_wr_accept", burst_write_o, 1);
        chk("b2b_wr_baddr", burst_address_o, 32'h0000_3000);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_rdata_kept", line_rdata_o, RD_LINE2);
            burst_resp_i = 1'b1;
            tick();
        end
        burst_resp_i = 1'b0;
        chk("b2b_wr_resp", line_resp_o, 1);
        line_write_i = 1'b0;
        tick();

        // Reset after two read beats discards the partial line.
        line_address_i = 32'h0000_4000;
        line_read_i    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = 64'hBAD0_0000_0000_0000 | 64'(k);
            tick();
        end
        burst_resp_i = 1'b0;
        line_read_i  = 1'b0;
        rst          = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_no_resp", line_resp_o, 0);
        burst_resp_i  = 1'b1;
        burst_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        burst_resp_i = 1'b0;
        chk("stray_resp_idle", {burst_read_o, burst_write_o, line_resp_o}, 0);
        chk("stray_resp_rdata", line_rdata_o, 0);

        run_read("rd_after_rst", 32'h0000_401F, RD_LINE3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache arbiter's physical-memory port. It accepts one 256-bit cache-line read or write request at a time on the line interface and returns a one-cycle response. Each line is carried on a 64-bit burst memory interface as four consecutive beats. It sits between the arbiter's memory port and the physical memory model or controller.

## Interface
- Parameters: none. Widths are fixed: 32-bit address, 256-bit line, 64-bit beat, 4 beats per line.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- line_address_i  in  32  line request address from arbiter.
- line_wdata_i  in  256  write line from arbiter.
- line_read_i  in  1  line read request, held until line_resp_o.
- line_write_i  in  1  line write request, held until line_resp_o.
- line_resp_o  out  1  one-cycle completion pulse to arbiter.
- line_rdata_o  out  256  read line; valid while line_resp_o=1 and held until the next accept.
- burst_address_o  out  32  line-aligned burst address to memory (bits [4:0]=0).
- burst_read_o  out  1  burst read request, held for the whole burst.
- burst_write_o  out  1  burst write request, held for the whole burst.
- burst_wdata_o  out  64  current write beat.
- burst_rdata_i  in  64  current read beat, valid when burst_resp_i=1.
- burst_resp_i  in  1  memory beat acknowledge, one per beat.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If line_write_i=1: latch the address with bits [4:0] forced to 0, latch line_wdata_i, clear the beat counter, go to WRITE. Write wins when read and write are both high.
  - Else if line_read_i=1: latch the address as above, clear the beat counter, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - burst_read_o=1 and burst_address_o=latched address, both constant.
  - On each burst_resp_i=1, store burst_rdata_i into line slot [64*k+63:64*k], where k is the beat counter, then increment k.
  - After the beat with k=3, go to DONE.
- WRITE:
  - burst_write_o=1, burst_address_o constant, burst_wdata_o=latched wdata[64*k+63:64*k].
  - On each burst_resp_i=1, increment k.
  - After the beat with k=3, go to DONE.
- Beat order is ascending: beat 0 carries line bits [63:0].
- DONE: line_resp_o=1 for exactly this cycle, then unconditional return to IDLE. In DONE, burst_read_o=0, burst_write_o=0, and requests are not sampled.
- Beat counter is 2 bits. After beat 3 it wraps to 0 but is never used past beat 3.
- burst_resp_i outside READ or WRITE is ignored.
- line_address_i and line_wdata_i changing after accept have no effect.
- Upstream must drop its request the cycle after line_resp_o. If the request is still high in the first IDLE cycle, it is accepted as a new request. This is the defined behaviour.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: line_resp_o=0, line_rdata_o=0, burst_read_o=0, burst_write_o=0, burst_address_o=0, burst_wdata_o=0, state=IDLE, beat counter=0.
- Request sampled in cycle T (IDLE) → burst_read_o or burst_write_o high from T+1.
- Zero-wait memory (burst_resp_i high T+1..T+4) → DONE and line_resp_o at T+5; earliest next accept at T+6.
- Wait states: any number of idle cycles between beats. Burst request and address stay stable, and burst_wdata_o holds the current beat.
- rst during any state: next cycle IDLE, all outputs at reset values, the partial line is discarded, no line_resp_o. The memory side is reset by the same rst.
- line_rdata_o updates only on read beats. It is not cleared on write requests.

## Test plan
- Reset: drive random inputs with rst=1 for 3 cycles → every output 0. Then idle 5 cycles → no burst_read_o, burst_write_o or line_resp_o.
- Zero-wait read at 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_address_o=0x0000_1220 from T+1. line_resp_o only at T+5. line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write of line 0xDEAD…BEEF to 0x8000_0040 with 2 wait cycles before each beat → burst_wdata_o shows words 0..3 in order, each held through its waits. burst_write_o is high for 12 cycles and line_resp_o pulses once.
- line_read_i=1 and line_write_i=1 together → write burst only, burst_read_o never high.
- Back-to-back: read, then write asserted the cycle after line_resp_o → write accepted in that IDLE cycle. line_rdata_o keeps the read data through the write.
- rst asserted after beat 1 of a read → outputs 0 next cycle. No line_resp_o, and a following read completes with correct data.
